uproc_sequencer: RTL and testbench
==================================

// Module: uproc_sequencer
// PURPOSE
//  Controller that steps the program ROM (PP) and drives the datapath strobes under a start/done handshake.
//  Replaces the free-running PC for controlled runs: fetch -> execute, with stall and halt detection.
//  Sits between the PP program ROM (combinational, addressed by addr) and the register file / ALU / A / CY enables.
// PARAMETERS
//  ADDR_W    5    program address width; PP address space is 2**ADDR_W words
//  PROG_LEN  32   number of valid program words; address PROG_LEN-1 is the last instruction (1..2**ADDR_W)
//  REG_W     4    width of the one-hot register select
//  ALU_W     3    width of the ALU opcode (`ADD, `SUB, ... from defines.sv)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       run request; sampled only in IDLE
//  stall        in   1       datapath hold request; freezes the sequencer while high
//  pp_reg_addr  in   REG_W   register select read from the PP word at addr
//  pp_alu_code  in   ALU_W   ALU opcode from the PP word
//  pp_reg_ce    in   1       register write enable from the PP word
//  pp_cy_ce     in   1       carry flag enable from the PP word
//  pp_a_ce      in   1       accumulator enable from the PP word
//  addr         out  ADDR_W  program address to PP
//  RegAddr      out  REG_W   register select to datapath
//  ALUCode      out  ALU_W   ALU opcode to datapath
//  Reg_CE       out  1       register write strobe
//  CY_CE        out  1       carry flag strobe
//  A_CE         out  1       accumulator strobe
//  busy         out  1       high from the first FETCH through DONE
//  done         out  1       one-cycle completion pulse
//  instr_cnt    out  ADDR_W+1  count of executed instructions in the current or last run
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; addr=0; IR=0; instr_cnt=0. All strobes, RegAddr, ALUCode, busy and done are 0.
//  States are IDLE, FETCH, EXEC and DONE.
//  IDLE: if start=1 at a clock edge, go to FETCH, set addr=0 and clear instr_cnt. Otherwise hold. busy=0.
//  FETCH: PP settles combinationally on addr.
//   - End marker: the PP word has pp_reg_ce=pp_cy_ce=pp_a_ce=0. Go to DONE; no EXEC is performed.
//   - Otherwise capture all PP fields into IR and go to EXEC.
//  EXEC: drive outputs from IR for exactly one cycle and increment instr_cnt.
//   - If addr==PROG_LEN-1, go to DONE.
//   - Otherwise set addr=addr+1 and go to FETCH.
//  DONE: done=1 for one cycle, then go to IDLE with addr=0. instr_cnt holds its value until the next start.
//  Datapath outputs equal IR only when state==EXEC and stall=0. Otherwise they are all 0.
//  Throughput is 2 cycles per instruction.
//  Latency: start sampled at edge t0 gives FETCH(addr 0) in cycle t0+1 and EXEC in cycle t0+2.
//  stall=1 in FETCH or EXEC: state, addr, IR and instr_cnt all hold.
//   - In EXEC the strobes are masked; the instruction executes in the first unstalled EXEC cycle.
//  stall has no effect in IDLE or DONE.
//  start while busy is ignored; it is not queued. start held high in DONE begins a new run only after IDLE is reached.
//  addr never exceeds PROG_LEN-1 and never wraps during a run. instr_cnt saturates at PROG_LEN.
//  Reset mid-run aborts immediately: no done pulse, and the strobes drop asynchronously.
// TESTING
//  PP words 0..3 {0001,`ADD,A_CE},{0010,`ADD,A_CE},{0100,`ADD,A_CE},{1000,`SUB,A_CE}, word 4 = 0; start at t0
//   -> A_CE pulses at t0+2,4,6,8 with RegAddr 0001/0010/0100/1000 and ALUCode ADD,ADD,ADD,SUB
//   -> done at t0+10, instr_cnt=4
//  Same program with stall=1 during cycles t0+4..t0+6
//   -> no strobe in those cycles; the second instruction executes at t0+7; done at t0+13; instr_cnt=4
//  PP word 0 = 0, start -> FETCH then DONE; done at t0+2; no strobes; instr_cnt=0
//  All 32 words nonzero, PROG_LEN=32 -> 32 EXEC pulses; done at t0+65; addr back to 0; instr_cnt=32
//  start pulses at t0+3 and t0+5 during a run -> ignored; exactly one done; busy stays 1 until done
//  rst asserted mid-cycle at t0+5 -> all outputs 0 immediately; IDLE; addr=0; no done; a later start runs from addr 0

Source files
------------

// File: rtl/uproc_sequencer.sv
// uproc_sequencer: fetch/execute controller stepping the PP program ROM under a start/done handshake
module uproc_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int REG_W    = 4,
  parameter int ALU_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [REG_W-1:0]  pp_reg_addr,
  input  logic [ALU_W-1:0]  pp_alu_code,
  input  logic              pp_reg_ce,
  input  logic              pp_cy_ce,
  input  logic              pp_a_ce,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  RegAddr,
  output logic [ALU_W-1:0]  ALUCode,
  output logic              Reg_CE,
  output logic              CY_CE,
  output logic              A_CE,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   instr_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [ADDR_W:0] r_cnt, w_cnt_nx;
  logic [REG_W-1:0] r_ir_reg;
  logic [ALU_W-1:0] r_ir_alu;
  logic [2:0] r_ir_ce;
  logic w_end, w_last, w_ld, w_exec;
  assign w_end  = !(pp_reg_ce || pp_cy_ce || pp_a_ce);
  assign w_last = r_addr == ADDR_W'(PROG_LEN - 1);
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_cnt_nx   = r_cnt;
    w_ld       = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nx = S_FETCH;
        w_addr_nx  = '0;
        w_cnt_nx   = '0;
      end
      S_FETCH: if (!stall) begin
        w_state_nx = w_end ? S_DONE : S_EXEC;
        w_ld       = !w_end;
      end
      S_EXEC: if (!stall) begin
        w_state_nx = w_last ? S_DONE : S_FETCH;
        w_addr_nx  = w_last ? r_addr : r_addr + 1'b1;
        w_cnt_nx   = (r_cnt == (ADDR_W + 1)'(PROG_LEN)) ? r_cnt : r_cnt + 1'b1;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_addr_nx  = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_ir_reg <= '0;
      r_ir_alu <= '0;
      r_ir_ce  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_cnt   <= w_cnt_nx;
      if (w_ld) begin
        r_ir_reg <= pp_reg_addr;
        r_ir_alu <= pp_alu_code;
        r_ir_ce  <= {pp_reg_ce, pp_cy_ce, pp_a_ce};
      end
    end
  // stall masks the strobes combinationally so a held EXEC never fires twice
  assign w_exec  = (r_state == S_EXEC) && !stall;
  assign RegAddr = w_exec ? r_ir_reg : '0;
  assign ALUCode = w_exec ? r_ir_alu : '0;
  assign {Reg_CE, CY_CE, A_CE} = w_exec ? r_ir_ce : 3'b000;
  assign addr      = r_addr;
  assign instr_cnt = r_cnt;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
endmodule

// File: tb/tb_uproc_sequencer.sv
// tb_uproc_sequencer: vector tables, directed corner runs and randomized runs against a program-level model
module tb_uproc_sequencer;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1;
  typedef struct {
    logic        st;
    logic        sl;
    logic [17:0] exp;
  } vec_t;
  logic clk = 1'b0, rst, start, stall;
  logic [9:0] rom [32];
  logic [3:0] pp_reg_addr, RegAddr;
  logic [2:0] pp_alu_code, ALUCode;
  logic pp_reg_ce, pp_cy_ce, pp_a_ce, Reg_CE, CY_CE, A_CE, busy, done;
  logic [4:0] addr;
  logic [5:0] instr_cnt;
  int tests = 0, fails = 0;
  vec_t tv[$];
  logic [9:0] got[$];
  always #5 clk = ~clk;
  assign {pp_reg_addr, pp_alu_code, pp_reg_ce, pp_cy_ce, pp_a_ce} = rom[addr];
  uproc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .pp_reg_addr(pp_reg_addr), .pp_alu_code(pp_alu_code),
    .pp_reg_ce(pp_reg_ce), .pp_cy_ce(pp_cy_ce), .pp_a_ce(pp_a_ce),
    .addr(addr), .RegAddr(RegAddr), .ALUCode(ALUCode),
    .Reg_CE(Reg_CE), .CY_CE(CY_CE), .A_CE(A_CE),
    .busy(busy), .done(done), .instr_cnt(instr_cnt)
  );
  function automatic vec_t v(logic st, logic sl, logic [3:0] ra, logic [2:0] alu,
                             logic [2:0] ce, logic b, logic d, logic [5:0] c);
    return '{st, sl, {ra, alu, ce, b, d, c}};
  endfunction
  function automatic logic [17:0] obs();
    return {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, busy, done, instr_cnt};
  endfunction
  function automatic logic [9:0] strobes();
    return {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load_prog1();
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = {4'b0001, ADD, 3'b001};
    rom[1] = {4'b0010, ADD, 3'b001};
    rom[2] = {4'b0100, ADD, 3'b001};
    rom[3] = {4'b1000, SUB, 3'b001};
  endtask
  // model: the run executes ROM words in order up to the first all-zero-enable word or the end of ROM
  function automatic int prog_len();
    for (int i = 0; i < 32; i++) if (rom[i][2:0] == 3'b000) return i;
    return 32;
  endfunction
  // called at a negedge; returns with the cycle after DONE sampled
  task automatic run(input int stall_pct, input bit rnd_start, output int ncyc);
    got.delete();
    ncyc = -1;
    start = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 400; k++) begin
      stall = $urandom_range(99) < stall_pct;
      start = rnd_start ? 1'($urandom_range(1)) : 1'b0;
      #1;
      chk("busy_in_run", {31'd0, busy}, 1);
      if (stall) chk("stall_mask", {22'd0, strobes()}, 0);
      if (A_CE || CY_CE || Reg_CE) got.push_back(strobes());
      if (done) begin
        ncyc = k;
        break;
      end
      @(negedge clk);
    end
    if (ncyc < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    #1;
    chk("done_one_cycle", {30'd0, done, busy}, 0);
    chk("addr_idle", {27'd0, addr}, 0);
  endtask
  task automatic check_run(string tag, int ncyc, int stall_pct);
    int n = prog_len();
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_instr"}, {22'd0, got[i]}, {22'd0, rom[i]});
    chk({tag, "_cnt"}, {26'd0, instr_cnt}, n);
    if (stall_pct == 0) chk({tag, "_latency"}, ncyc, n == 32 ? 2 * n + 1 : 2 * n + 2);
  endtask
  initial begin
    int nc;
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    load_prog1();
    #1;
    chk("reset_out", {14'd0, obs()}, 0);
    chk("reset_addr", {27'd0, addr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // plain program, with start pulses at t0+3 and t0+5 that must be ignored
    tv.push_back(v(1, 0, 4'b0000, ADD, 3'b000, 0, 0, 0));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 0));
    tv.push_back(v(0, 0, 4'b0001, ADD, 3'b001, 1, 0, 0));
    tv.push_back(v(1, 0, 4'b0000, ADD, 3'b000, 1, 0, 1));
    tv.push_back(v(0, 0, 4'b0010, ADD, 3'b001, 1, 0, 1));
    tv.push_back(v(1, 0, 4'b0000, ADD, 3'b000, 1, 0, 2));
    tv.push_back(v(0, 0, 4'b0100, ADD, 3'b001, 1, 0, 2));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 3));
    tv.push_back(v(0, 0, 4'b1000, SUB, 3'b001, 1, 0, 3));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 4));
    tv.push_back(v(0, 1, 4'b0000, ADD, 3'b000, 1, 1, 4));
    tv.push_back(v(0, 1, 4'b0000, ADD, 3'b000, 0, 0, 4));
    // stall during t0+4..t0+6 delays the second instruction to t0+7
    tv.push_back(v(1, 0, 4'b0000, ADD, 3'b000, 0, 0, 4));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 0));
    tv.push_back(v(0, 0, 4'b0001, ADD, 3'b001, 1, 0, 0));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 1));
    tv.push_back(v(0, 1, 4'b0000, ADD, 3'b000, 1, 0, 1));
    tv.push_back(v(0, 1, 4'b0000, ADD, 3'b000, 1, 0, 1));
    tv.push_back(v(0, 1, 4'b0000, ADD, 3'b000, 1, 0, 1));
    tv.push_back(v(0, 0, 4'b0010, ADD, 3'b001, 1, 0, 1));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 2));
    tv.push_back(v(0, 0, 4'b0100, ADD, 3'b001, 1, 0, 2));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 3));
    tv.push_back(v(0, 0, 4'b1000, SUB, 3'b001, 1, 0, 3));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 0, 4));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 1, 1, 4));
    tv.push_back(v(0, 0, 4'b0000, ADD, 3'b000, 0, 0, 4));
    foreach (tv[i]) begin
      start = tv[i].st;
      stall = tv[i].sl;
      #1;
      chk($sformatf("vec%0d", i), {14'd0, obs()}, {14'd0, tv[i].exp});
      @(negedge clk);
    end
    // empty program: FETCH then DONE
    rom[0] = '0;
    run(0, 0, nc);
    chk("empty_done", nc, 2);
    check_run("empty", nc, 0);
    // full ROM: every word executes, no wrap
    for (int i = 0; i < 32; i++) rom[i] = {4'($urandom), 3'($urandom), 3'($urandom_range(7, 1))};
    run(0, 0, nc);
    chk("full_done", nc, 65);
    check_run("full", nc, 0);
    // reset in the middle of the second EXEC
    load_prog1();
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre_rst_strobe", {22'd0, strobes()}, {22'd0, rom[1]});
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out", {14'd0, obs()}, 0);
    chk("rst_async_addr", {27'd0, addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      #1;
      chk("rst_no_done", {30'd0, busy, done}, 0);
      @(negedge clk);
    end
    run(0, 0, nc);
    check_run("after_rst", nc, 0);
    // randomized programs, stalls and stray start pulses
    for (int r = 0; r < 24; r++) begin
      int pct = (r % 3 == 0) ? 0 : 35;
      int cut = $urandom_range(40);
      for (int i = 0; i < 32; i++) rom[i] = {4'($urandom), 3'($urandom), 3'($urandom_range(7, 1))};
      if (cut < 32) rom[cut][2:0] = 3'b000;
      run(pct, r % 2 == 1, nc);
      check_run("rand", nc, pct);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
